// File: rtl/commit_rmap_pkg.sv
// commit_rmap_pkg
// Shared types and sizing for the retirement-side register map.
//   CWD / RWD   commit width and rename width
//   PRN / PW    physical register count and index width
//   NLREG       architectural (logical) register count
//   preg_t      physical register index
//   ptr_t       free-list pointer, one wrap bit above the index
//   com_bundle_t  one commit-bundle entry as produced by commit
package commit_rmap_pkg;

    localparam int unsigned CWD   = 4;
    localparam int unsigned RWD   = 4;
    localparam int unsigned PRN   = 128;
    localparam int unsigned PW    = $clog2(PRN);
    localparam int unsigned NLREG = 32;
    localparam int unsigned ANW   = $clog2(RWD + 1);
    localparam int unsigned CNTW  = $clog2(CWD + 1);
    localparam int unsigned CIW   = $clog2(CWD);

    typedef logic [PW-1:0] preg_t;
    typedef logic [PW:0]   ptr_t;
    typedef logic [4:0]    lreg_t;

    typedef struct packed {
        logic [15:0] opid;
        logic        redir;
        logic        rollback;
        lreg_t       lrda;
        preg_t       prda;
    } com_bundle_t;

    // The ring is indexed by the low bits; the top bit only tells full from empty.
    function automatic preg_t ptr_idx(ptr_t p);
        return p[PW-1:0];
    endfunction

endpackage

// File: rtl/commit_rmap_if.sv
// commit_rmap_if
// Bundles everything that flows between commit/rename and the register map.
//   com_bundle  commit bundle from commit (CWD entries)
//   alloc_num   registers rename takes this cycle
//   free_preg   next RWD free physical registers
//   avail_num   free registers available to rename
//   arch_map    committed logical->physical map
//   recover     one-cycle pulse after a redirect, arch_map is final
// master: commit/rename side. slave: the register map.
interface commit_rmap_if;
    import commit_rmap_pkg::*;

    com_bundle_t [CWD-1:0]   com_bundle;
    logic        [ANW-1:0]   alloc_num;
    preg_t       [RWD-1:0]   free_preg;
    ptr_t                    avail_num;
    preg_t       [NLREG-1:0] arch_map;
    logic                    recover;

    modport master (
        output com_bundle, alloc_num,
        input  free_preg, avail_num, arch_map, recover
    );

    modport slave (
        input  com_bundle, alloc_num,
        output free_preg, avail_num, arch_map, recover
    );

endinterface

// File: rtl/commit_rmap_preg_freelist.sv
// commit_rmap_preg_freelist
// Circular free list of physical registers with three pointers:
//   spec_head  next register handed to rename (speculative)
//   com_head   oldest allocation not yet committed
//   tail       where released registers are appended
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pop_num_i       registers rename takes (clamped to what is available)
//   push_num_i      released registers appended this cycle
//   push_preg_i     released registers, compacted to the low entries
//   rollback_i      rewind spec_head by rewind_num_i
//   rewind_num_i    number of speculative allocations returned
//   rewind_preg_i   registers being returned, youngest first
//   redirect_i      snap spec_head back to com_head
//   free_preg_o     list[spec_head + i]
//   avail_num_o     tail - spec_head
module commit_rmap_preg_freelist
    import commit_rmap_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic     [ANW-1:0]   pop_num_i,
    input  logic     [CNTW-1:0]  push_num_i,
    input  preg_t    [CWD-1:0]   push_preg_i,
    input  logic                 rollback_i,
    input  logic     [CNTW-1:0]  rewind_num_i,
    input  preg_t    [CWD-1:0]   rewind_preg_i,
    input  logic                 redirect_i,
    output preg_t    [RWD-1:0]   free_preg_o,
    output ptr_t                 avail_num_o
);

    preg_t [PRN-1:0] list_q;
    ptr_t            spec_head_q, spec_head_d;
    ptr_t            com_head_q, com_head_d;
    ptr_t            tail_q, tail_d;
    ptr_t            pop_eff;
    logic  [CWD-1:0] wr_en;
    preg_t [CWD-1:0] wr_idx;

    assign avail_num_o = tail_q - spec_head_q;

    always_comb begin
        for (int unsigned i = 0; i < RWD; i++) begin
            free_preg_o[i] = list_q[ptr_idx(spec_head_q + ptr_t'(i))];
        end
    end

    // An over-ask from rename is illegal; clamping keeps spec_head from
    // running past tail and corrupting the ring if it ever happens.
    always_comb begin
        pop_eff = (ptr_t'(pop_num_i) > avail_num_o) ? avail_num_o : ptr_t'(pop_num_i);
    end

    // Pointer update. Redirect and rollback freeze commit and pop entirely.
    always_comb begin
        spec_head_d = spec_head_q;
        com_head_d  = com_head_q;
        tail_d      = tail_q;
        if (redirect_i) begin
            spec_head_d = com_head_q;
        end else if (rollback_i) begin
            spec_head_d = spec_head_q - ptr_t'(rewind_num_i);
        end else begin
            spec_head_d = spec_head_q + pop_eff;
            com_head_d  = com_head_q + ptr_t'(push_num_i);
            tail_d      = tail_q + ptr_t'(push_num_i);
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < CWD; k++) begin
            wr_en[k]  = !redirect_i && !rollback_i && (CNTW'(k) < push_num_i);
            wr_idx[k] = ptr_idx(tail_q + ptr_t'(k));
        end
    end

    // After reset, registers 0..31 back the architectural state and the
    // remaining ones are queued in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned j = 0; j < PRN; j++) begin
                list_q[j] <= (j < PRN - NLREG) ? preg_t'(j + NLREG) : '0;
            end
            spec_head_q <= '0;
            com_head_q  <= '0;
            tail_q      <= ptr_t'(PRN - NLREG);
        end else begin
            for (int unsigned k = 0; k < CWD; k++) begin
                if (wr_en[k]) begin
                    list_q[wr_idx[k]] <= push_preg_i[k];
                end
            end
            spec_head_q <= spec_head_d;
            com_head_q  <= com_head_d;
            tail_q      <= tail_d;
        end
    end

    // Structural invariants of the ring and the rename/commit contract.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (ptr_t'(tail_q - com_head_q) == ptr_t'(PRN - NLREG));
            assert (ptr_t'(spec_head_q - com_head_q) <= ptr_t'(PRN - NLREG));
            if (!redirect_i && !rollback_i) begin
                assert (ptr_t'(pop_num_i) <= avail_num_o);
            end
            if (rollback_i && !redirect_i) begin
                for (int unsigned k = 0; k < CWD; k++) begin
                    if (CNTW'(k) < rewind_num_i) begin
                        assert (rewind_preg_i[k] == list_q[ptr_idx(spec_head_q - ptr_t'(k + 1))]);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/commit_rmap.sv
// commit_rmap
// Retirement-side register map and physical-register free list.
// Commits update the architectural map and release the overwritten physical
// register; rollback entries return speculative allocations; a redirect
// rewinds the free list and pulses recover so rename can reload arch_map.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   commit_rmap_if.slave (com_bundle, alloc_num in; free_preg,
//         avail_num, arch_map, recover out)
module commit_rmap
    import commit_rmap_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    commit_rmap_if.slave     bus
);

    preg_t [NLREG-1:0] arch_map_q, arch_map_d;
    logic              recover_q, recover_d;
    logic              redir;
    logic              rollback_any;
    logic  [CWD-1:0]   live;
    preg_t [CWD-1:0]   old_preg;
    preg_t [CWD-1:0]   push_preg;
    logic  [CNTW-1:0]  push_num;
    preg_t [CWD-1:0]   rewind_preg;
    logic  [CNTW-1:0]  rewind_num;
    logic              unused_bits;

    // Cycle classification: redirect beats rollback beats commit.
    always_comb begin
        redir        = bus.com_bundle[0].redir;
        rollback_any = 1'b0;
        for (int unsigned i = 0; i < CWD; i++) begin
            rollback_any = rollback_any | bus.com_bundle[i].rollback;
        end
        for (int unsigned i = 0; i < CWD; i++) begin
            live[i] = !redir && !rollback_any && bus.com_bundle[i].opid[15]
                      && (bus.com_bundle[i].lrda != '0);
        end
    end

    // The register a commit frees is whatever its logical register pointed at
    // just before it, which may be an earlier entry of this same bundle.
    always_comb begin
        for (int unsigned i = 0; i < CWD; i++) begin
            old_preg[i] = arch_map_q[bus.com_bundle[i].lrda];
            for (int unsigned j = 0; j < i; j++) begin
                if (live[j] && (bus.com_bundle[j].lrda == bus.com_bundle[i].lrda)) begin
                    old_preg[i] = bus.com_bundle[j].prda;
                end
            end
        end
    end

    // Pack freed registers in bundle order so the list sees a dense push.
    always_comb begin
        push_num  = '0;
        push_preg = '0;
        for (int unsigned i = 0; i < CWD; i++) begin
            if (live[i]) begin
                push_preg[push_num[CIW-1:0]] = old_preg[i];
                push_num = push_num + CNTW'(1);
            end
        end
    end

    // Rollback returns allocations for every entry that had a destination;
    // entries arrive youngest first so rank k matches list[spec_head-1-k].
    always_comb begin
        rewind_num  = '0;
        rewind_preg = '0;
        for (int unsigned i = 0; i < CWD; i++) begin
            if (rollback_any && !redir && (bus.com_bundle[i].lrda != '0)) begin
                rewind_preg[rewind_num[CIW-1:0]] = bus.com_bundle[i].prda;
                rewind_num = rewind_num + CNTW'(1);
            end
        end
    end

    // Map update in bundle order so the youngest writer of a register wins.
    always_comb begin
        arch_map_d = arch_map_q;
        for (int unsigned i = 0; i < CWD; i++) begin
            if (live[i]) begin
                arch_map_d[bus.com_bundle[i].lrda] = bus.com_bundle[i].prda;
            end
        end
        recover_d = redir;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NLREG; i++) begin
                arch_map_q[i] <= preg_t'(i);
            end
            recover_q <= 1'b0;
        end else begin
            arch_map_q <= arch_map_d;
            recover_q  <= recover_d;
        end
    end

    // Bundle fields this block has no use for.
    always_comb begin
        unused_bits = 1'b0;
        for (int unsigned i = 0; i < CWD; i++) begin
            unused_bits = unused_bits ^ (^bus.com_bundle[i].opid[14:0]);
            if (i != 0) begin
                unused_bits = unused_bits ^ bus.com_bundle[i].redir;
            end
        end
    end

    commit_rmap_preg_freelist u_freelist (
        .clk           (clk),
        .rst           (rst),
        .pop_num_i     (bus.alloc_num),
        .push_num_i    (push_num),
        .push_preg_i   (push_preg),
        .rollback_i    (rollback_any),
        .rewind_num_i  (rewind_num),
        .rewind_preg_i (rewind_preg),
        .redirect_i    (redir),
        .free_preg_o   (bus.free_preg),
        .avail_num_o   (bus.avail_num)
    );

    assign bus.arch_map = arch_map_q;
    assign bus.recover  = recover_q;

endmodule

// File: tb/tb_commit_rmap.sv
// tb_commit_rmap
// Directed checks of the register map: reset image, single commit, same-register
// forwarding inside a bundle, rollback, redirect/recover, and a long run of
// alloc/commit pairs with occasional redirects against a small queue model.
module tb_commit_rmap;
    import commit_rmap_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    commit_rmap_if bus ();

    commit_rmap dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic com_bundle_t mkEntry(logic v, logic rb, logic rd, lreg_t lr, preg_t pr);
        com_bundle_t e;
        e          = '0;
        e.opid     = 16'h0123;
        e.opid[15] = v;
        e.rollback = rb;
        e.redir    = rd;
        e.lrda     = lr;
        e.prda     = pr;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input com_bundle_t [CWD-1:0] b, input logic [ANW-1:0] n);
        bus.com_bundle = b;
        bus.alloc_num  = n;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus('0, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Pop n registers, at most four a cycle, with an idle commit bundle.
    task automatic drain(input int n);
        int left;
        left = n;
        while (left > 0) begin
            applyStimulus('0, ANW'((left > 4) ? 4 : left));
            tick();
            left = left - ((left > 4) ? 4 : left);
        end
        applyStimulus('0, '0);
    endtask

    task automatic test_reset();
        doReset();
        total++;
        if (bus.avail_num !== 8'd96) begin
            bad++;
            $display("[TB] FAIL reset_avail got=%0d exp=96", bus.avail_num);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.free_preg[i] !== preg_t'(32 + i)) begin
                bad++;
                $display("[TB] FAIL reset_free_preg[%0d] got=%0d exp=%0d", i, bus.free_preg[i], 32 + i);
            end
        end
        total++;
        if (bus.arch_map[5] !== 7'd5) begin
            bad++;
            $display("[TB] FAIL reset_arch_map5 got=%0d exp=5", bus.arch_map[5]);
        end
        total++;
        if (bus.recover !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_recover got=%0b exp=0", bus.recover);
        end
    endtask

    task automatic test_commit();
        com_bundle_t [CWD-1:0] b;
        doReset();
        applyStimulus('0, 3'd2);
        tick();
        b    = '0;
        b[0] = mkEntry(1'b1, 1'b0, 1'b0, 5'd5, 7'd32);
        applyStimulus(b, '0);
        tick();
        applyStimulus('0, '0);
        total++;
        if (bus.arch_map[5] !== 7'd32) begin
            bad++;
            $display("[TB] FAIL commit_arch_map5 got=%0d exp=32", bus.arch_map[5]);
        end
        total++;
        if (bus.avail_num !== 8'd95) begin
            bad++;
            $display("[TB] FAIL commit_avail got=%0d exp=95", bus.avail_num);
        end
        total++;
        if (bus.free_preg[0] !== 7'd34) begin
            bad++;
            $display("[TB] FAIL commit_head got=%0d exp=34", bus.free_preg[0]);
        end
        // Walk spec_head up to slot 96 to see the released register.
        drain(94);
        total++;
        if (bus.free_preg[0] !== 7'd5) begin
            bad++;
            $display("[TB] FAIL commit_list96 got=%0d exp=5", bus.free_preg[0]);
        end
        total++;
        if (bus.avail_num !== 8'd1) begin
            bad++;
            $display("[TB] FAIL commit_avail_drained got=%0d exp=1", bus.avail_num);
        end
    endtask

    task automatic test_same_lrda();
        com_bundle_t [CWD-1:0] b;
        doReset();
        applyStimulus('0, 3'd2);
        tick();
        b    = '0;
        b[0] = mkEntry(1'b1, 1'b0, 1'b0, 5'd7, 7'd32);
        b[1] = mkEntry(1'b1, 1'b0, 1'b0, 5'd7, 7'd33);
        b[2] = mkEntry(1'b0, 1'b0, 1'b0, 5'd9, 7'd50);
        b[3] = mkEntry(1'b1, 1'b0, 1'b0, 5'd0, 7'd51);
        applyStimulus(b, '0);
        tick();
        applyStimulus('0, '0);
        total++;
        if (bus.arch_map[7] !== 7'd33) begin
            bad++;
            $display("[TB] FAIL fwd_arch_map7 got=%0d exp=33", bus.arch_map[7]);
        end
        total++;
        if (bus.arch_map[9] !== 7'd9) begin
            bad++;
            $display("[TB] FAIL fwd_invalid_entry got=%0d exp=9", bus.arch_map[9]);
        end
        total++;
        if (bus.arch_map[0] !== 7'd0) begin
            bad++;
            $display("[TB] FAIL fwd_x0 got=%0d exp=0", bus.arch_map[0]);
        end
        total++;
        if (bus.avail_num !== 8'd96) begin
            bad++;
            $display("[TB] FAIL fwd_avail got=%0d exp=96", bus.avail_num);
        end
        drain(94);
        total++;
        if (bus.free_preg[0] !== 7'd7) begin
            bad++;
            $display("[TB] FAIL fwd_list96 got=%0d exp=7", bus.free_preg[0]);
        end
        total++;
        if (bus.free_preg[1] !== 7'd32) begin
            bad++;
            $display("[TB] FAIL fwd_list97 got=%0d exp=32", bus.free_preg[1]);
        end
        total++;
        if (bus.avail_num !== 8'd2) begin
            bad++;
            $display("[TB] FAIL fwd_avail_drained got=%0d exp=2", bus.avail_num);
        end
    endtask

    task automatic test_rollback();
        com_bundle_t [CWD-1:0] b;
        doReset();
        applyStimulus('0, 3'd3);
        tick();
        b    = '0;
        b[0] = mkEntry(1'b1, 1'b1, 1'b0, 5'd3, 7'd34);
        b[1] = mkEntry(1'b1, 1'b1, 1'b0, 5'd2, 7'd33);
        b[2] = mkEntry(1'b1, 1'b1, 1'b0, 5'd0, 7'd0);
        applyStimulus(b, 3'd2);
        tick();
        applyStimulus('0, '0);
        total++;
        if (bus.free_preg[0] !== 7'd33) begin
            bad++;
            $display("[TB] FAIL rollback_head got=%0d exp=33", bus.free_preg[0]);
        end
        total++;
        if (bus.free_preg[1] !== 7'd34) begin
            bad++;
            $display("[TB] FAIL rollback_head1 got=%0d exp=34", bus.free_preg[1]);
        end
        total++;
        if (bus.avail_num !== 8'd95) begin
            bad++;
            $display("[TB] FAIL rollback_avail got=%0d exp=95", bus.avail_num);
        end
        total++;
        if (bus.arch_map[3] !== 7'd3) begin
            bad++;
            $display("[TB] FAIL rollback_arch_map3 got=%0d exp=3", bus.arch_map[3]);
        end
    endtask

    task automatic test_redirect();
        com_bundle_t [CWD-1:0] b;
        doReset();
        applyStimulus('0, 3'd4);
        tick();
        applyStimulus('0, 3'd1);
        tick();
        b    = '0;
        b[0] = mkEntry(1'b1, 1'b0, 1'b0, 5'd1, 7'd32);
        applyStimulus(b, '0);
        tick();
        total++;
        if (bus.avail_num !== 8'd92) begin
            bad++;
            $display("[TB] FAIL redir_pre_avail got=%0d exp=92", bus.avail_num);
        end
        b    = '0;
        b[0] = mkEntry(1'b0, 1'b0, 1'b1, 5'd4, 7'd60);
        applyStimulus(b, 3'd3);
        total++;
        if (bus.recover !== 1'b0) begin
            bad++;
            $display("[TB] FAIL redir_recover_early got=%0b exp=0", bus.recover);
        end
        tick();
        applyStimulus('0, '0);
        total++;
        if (bus.recover !== 1'b1) begin
            bad++;
            $display("[TB] FAIL redir_recover got=%0b exp=1", bus.recover);
        end
        total++;
        if (bus.avail_num !== 8'd96) begin
            bad++;
            $display("[TB] FAIL redir_avail got=%0d exp=96", bus.avail_num);
        end
        total++;
        if (bus.free_preg[0] !== 7'd33) begin
            bad++;
            $display("[TB] FAIL redir_head got=%0d exp=33", bus.free_preg[0]);
        end
        total++;
        if (bus.arch_map[1] !== 7'd32) begin
            bad++;
            $display("[TB] FAIL redir_arch_map1 got=%0d exp=32", bus.arch_map[1]);
        end
        tick();
        total++;
        if (bus.recover !== 1'b0) begin
            bad++;
            $display("[TB] FAIL redir_recover_pulse got=%0b exp=0", bus.recover);
        end
    endtask

    // 300 alloc/commit pairs with random redirects; the free list is modelled
    // as a queue: pop at the front, released registers at the back, and a
    // redirected allocation goes back to the front.
    task automatic test_back_to_back();
        com_bundle_t [CWD-1:0] b;
        preg_t freeQ[$];
        preg_t archM[NLREG];
        preg_t p;
        lreg_t lr;
        doReset();
        for (int i = 0; i < int'(NLREG); i++) archM[i] = preg_t'(i);
        for (int j = int'(NLREG); j < int'(PRN); j++) freeQ.push_back(preg_t'(j));
        for (int i = 0; i < 300; i++) begin
            lr = lreg_t'(1 + (i % 31));
            p  = freeQ[0];
            total++;
            if (bus.free_preg[0] !== p) begin
                bad++;
                $display("[TB] FAIL wrap_head iter=%0d got=%0d exp=%0d", i, bus.free_preg[0], p);
            end
            applyStimulus('0, 3'd1);
            tick();
            void'(freeQ.pop_front());
            b = '0;
            if ($urandom_range(0, 7) == 0) begin
                b[0] = mkEntry(1'b0, 1'b0, 1'b1, 5'd0, 7'd0);
                applyStimulus(b, '0);
                tick();
                freeQ.push_front(p);
                applyStimulus('0, '0);
                total++;
                if (bus.recover !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL wrap_recover iter=%0d got=%0b exp=1", i, bus.recover);
                end
            end else begin
                b[0] = mkEntry(1'b1, 1'b0, 1'b0, lr, p);
                applyStimulus(b, '0);
                tick();
                freeQ.push_back(archM[lr]);
                archM[lr] = p;
                applyStimulus('0, '0);
            end
        end
        tick();
        total++;
        if (bus.avail_num !== 8'd96) begin
            bad++;
            $display("[TB] FAIL wrap_avail got=%0d exp=96", bus.avail_num);
        end
        for (int i = 0; i < int'(NLREG); i++) begin
            total++;
            if (bus.arch_map[i] !== archM[i]) begin
                bad++;
                $display("[TB] FAIL wrap_arch_map[%0d] got=%0d exp=%0d", i, bus.arch_map[i], archM[i]);
            end
        end
    endtask

    initial begin
        applyStimulus('0, '0);
        test_reset();
        test_commit();
        test_same_lrda();
        test_rollback();
        test_redirect();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
